// File: rtl/axi_rd_rr_arbiter_if.sv
// Read-side bus bundle between the requesting masters, the round-robin arbiter and the core read port.
// The slave modport is the arbiter's view; the master modport is the masters-plus-core environment.
interface axi_rd_rr_arbiter_if #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_read_request_valid;
  logic [NUM_REQ-1:0]            req_read_request_ready;
  logic [NUM_REQ*AXI_AWIDTH-1:0] req_read_addr;
  logic [NUM_REQ*32-1:0]         req_read_len;
  logic [NUM_REQ*3-1:0]          req_read_size;
  logic [NUM_REQ*2-1:0]          req_read_burst;
  logic [AXI_DWIDTH-1:0]         req_read_data;
  logic [NUM_REQ-1:0]            req_read_data_valid;
  logic [NUM_REQ-1:0]            req_read_data_ready;

  logic                          core_read_request_valid;
  logic                          core_read_request_ready;
  logic [AXI_AWIDTH-1:0]         core_read_addr;
  logic [31:0]                   core_read_len;
  logic [2:0]                    core_read_size;
  logic [1:0]                    core_read_burst;
  logic [AXI_DWIDTH-1:0]         core_read_data;
  logic                          core_read_data_valid;
  logic                          core_read_data_ready;

  modport slave (
    input  req_read_request_valid, req_read_addr, req_read_len, req_read_size, req_read_burst,
    output req_read_request_ready,
    output req_read_data, req_read_data_valid,
    input  req_read_data_ready,
    output core_read_request_valid, core_read_addr, core_read_len, core_read_size, core_read_burst,
    input  core_read_request_ready,
    input  core_read_data, core_read_data_valid,
    output core_read_data_ready
  );

  modport master (
    output req_read_request_valid, req_read_addr, req_read_len, req_read_size, req_read_burst,
    input  req_read_request_ready,
    input  req_read_data, req_read_data_valid,
    output req_read_data_ready,
    input  core_read_request_valid, core_read_addr, core_read_len, core_read_size, core_read_burst,
    output core_read_request_ready,
    output core_read_data, core_read_data_valid,
    input  core_read_data_ready
  );
endinterface

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin burst arbiter for the shared core read port: 1 arbitration cycle before the request, data/ready pass
// through combinationally to the granted master, grant held until the last beat. Optional watchdog: RD_ARB_TIMEOUT_EN.
module axi_rd_rr_arbiter #(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_rd_rr_arbiter_if.slave        bus,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                r_state;
  logic [2:0]            r_rr_ptr;
  logic [2:0]            r_grant;
  logic [AXI_AWIDTH-1:0] r_addr;
  logic [31:0]           r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [31:0]           r_cnt;

  logic                  w_found;
  logic [2:0]            w_winner;
  logic [3:0]            w_idx;
  logic [15:0]           w_vld_pad;
  logic [7:0]            w_dready_pad;
  logic                  w_req_hs;
  logic                  w_beat_acc;
  logic                  w_timeout;

  assign w_vld_pad    = 16'(bus.req_read_request_valid);
  assign w_dready_pad = 8'(bus.req_read_data_ready);

  // Search starts one past the last winner and wraps, so each master waits at most NUM_REQ-1 bursts.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + 4'd1 + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) w_idx = w_idx - 4'(NUM_REQ);
      if (!w_found && w_vld_pad[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  assign w_req_hs   = (r_state == REQ) && bus.core_read_request_ready;
  assign w_beat_acc = (r_state == DATA) && bus.core_read_data_valid && w_dready_pad[r_grant];

  assign bus.core_read_request_valid = (r_state == REQ);
  assign bus.core_read_addr          = r_addr;
  assign bus.core_read_len           = r_len;
  assign bus.core_read_size          = r_size;
  assign bus.core_read_burst         = r_burst;
  assign bus.core_read_data_ready    = (r_state == DATA) && w_dready_pad[r_grant];
  // Data bus is zeroed outside DATA so stray core beats never reach the masters.
  assign bus.req_read_data           = (r_state == DATA) ? bus.core_read_data : '0;

  always_comb begin
    bus.req_read_request_ready = '0;
    bus.req_read_data_valid    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        bus.req_read_request_ready[i] = w_req_hs;
        bus.req_read_data_valid[i]    = (r_state == DATA) && bus.core_read_data_valid;
      end
    end
  end

`ifdef RD_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] r_stall;
  logic          r_timeout_err;

  assign w_timeout = (r_state != IDLE) && !w_req_hs && !w_beat_acc &&
                     ((r_stall + SW'(1)) == SW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE || w_req_hs || w_beat_acc || w_timeout) r_stall <= '0;
      else                                                         r_stall <= r_stall + SW'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  // Stall limit is only meaningful with the watchdog compiled in.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= 3'(NUM_REQ - 1);
      r_grant  <= 3'd0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant  <= w_winner;
            r_rr_ptr <= w_winner;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (w_winner == 3'(i)) begin
                r_addr  <= bus.req_read_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
                r_len   <= bus.req_read_len[i*32 +: 32];
                r_size  <= bus.req_read_size[i*3 +: 3];
                r_burst <= bus.req_read_burst[i*2 +: 2];
              end
            end
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_timeout) begin
            r_state <= IDLE;
          end else if (w_req_hs) begin
            r_cnt   <= r_len;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_timeout) begin
            r_state <= IDLE;
          end else if (w_beat_acc) begin
            if (r_cnt == 32'd0) r_state <= IDLE;
            else                r_cnt   <= r_cnt - 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed bench for axi_rd_rr_arbiter: per-master request queues and an expected-beat queue act as the scoreboard,
// a small core model answers bursts, and a negedge monitor checks grants, routing, data order and idle gaps.
module tb_axi_rd_rr_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  axi_rd_rr_arbiter_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .NUM_REQ(NR)) bus ();

  axi_rd_rr_arbiter #(
    .AXI_AWIDTH(32), .AXI_DWIDTH(32), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {logic [31:0] addr; logic [31:0] len;} rq_t;
  typedef struct {int m; logic [31:0] dat;} bt_t;

  rq_t         mq[NR][$];
  bt_t         exp_b[$];
  logic [31:0] core_pend[$];
  int          grant_log[$];
  int          errors = 0;
  int          checks = 0;
  int          model_rr = NR - 1;
  int          pred = -1;
  logic        gap_chk = 1'b0;
  int          beats_m[NR];
  int          rdy_pulses[NR];
  logic        core_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_m();
    for (int i = 0; i < NR; i++) begin
      if (mq[i].size() != 0) begin
        bus.req_read_request_valid[i]  = 1'b1;
        bus.req_read_addr[i*32 +: 32]  = mq[i][0].addr;
        bus.req_read_len[i*32 +: 32]   = mq[i][0].len;
      end else begin
        bus.req_read_request_valid[i]  = 1'b0;
        bus.req_read_addr[i*32 +: 32]  = 32'd0;
        bus.req_read_len[i*32 +: 32]   = 32'd0;
      end
      bus.req_read_size[i*3 +: 3]  = 3'd2;
      bus.req_read_burst[i*2 +: 2] = 2'b01;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while (!(mq[0].size() == 0 && mq[1].size() == 0 && exp_b.size() == 0 &&
             core_pend.size() == 0 && !busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  // Monitor and master driver: the only process that drives the master-side request inputs.
  always @(negedge clk) begin
    int c;
    upd_m();
    if (rst) begin
      exp_b.delete();
      model_rr = NR - 1;
      pred     = -1;
      gap_chk  = 1'b0;
    end else begin
      if (gap_chk) begin
        chk("idle_gap", busy, 1'b0);
        gap_chk = 1'b0;
      end
      if (!busy && bus.req_read_request_valid != '0) begin
        pred = -1;
        for (int k = 1; k <= NR; k++) begin
          c = (model_rr + k) % NR;
          if (pred < 0 && bus.req_read_request_valid[c]) pred = c;
        end
        model_rr = pred;
      end
      for (int i = 0; i < NR; i++) if (bus.req_read_request_ready[i]) rdy_pulses[i]++;
      if (bus.core_read_request_valid && bus.core_read_request_ready) begin
        grant_log.push_back(int'(grant_id));
        if (pred < 0 || mq[pred].size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          chk("grant_rr", grant_id, 32'(pred));
          chk("req_ready_onehot", bus.req_read_request_ready, 32'd1 << pred);
          chk("req_addr", bus.core_read_addr, mq[pred][0].addr);
          chk("req_len", bus.core_read_len, mq[pred][0].len);
          for (int b = 0; b <= int'(mq[pred][0].len); b++)
            exp_b.push_back('{pred, mq[pred][0].addr + 32'(b * 4)});
          mq[pred].pop_front();
          pred = -1;
        end
      end else begin
        chk("req_ready_idle", bus.req_read_request_ready, 32'd0);
      end
      if (bus.req_read_data_valid != '0) begin
        if (exp_b.size() == 0) begin
          chk("spurious_beat", bus.req_read_data_valid, 32'd0);
        end else begin
          chk("beat_route", bus.req_read_data_valid, 32'd1 << exp_b[0].m);
          chk("beat_data", bus.req_read_data, exp_b[0].dat);
          chk("core_dready", bus.core_read_data_ready, bus.req_read_data_ready[exp_b[0].m]);
          chk("busy_in_burst", busy, 1'b1);
          if (bus.req_read_data_ready[exp_b[0].m]) begin
            beats_m[exp_b[0].m]++;
            exp_b.pop_front();
            if (exp_b.size() == 0) gap_chk = 1'b1;
          end
        end
      end
      upd_m();
    end
  end

  // Core model: queues len+1 beats (data = addr + 4*beat) after each request handshake.
  always begin
    logic        hs, acc, r;
    logic [31:0] ad, ln;
    @(negedge clk);
    hs  = bus.core_read_request_valid && bus.core_read_request_ready;
    acc = bus.core_read_data_valid && bus.core_read_data_ready;
    ad  = bus.core_read_addr;
    ln  = bus.core_read_len;
    r   = rst;
    @(posedge clk);
    #1;
    if (r) begin
      core_pend.delete();
    end else begin
      if (acc && core_pend.size() != 0) core_pend.pop_front();
      if (hs) for (int b = 0; b <= int'(ln) && b < 64; b++) core_pend.push_back(ad + 32'(b * 4));
    end
    bus.core_read_data_valid = core_en && (core_pend.size() != 0);
    bus.core_read_data       = (core_pend.size() != 0) ? core_pend[0] : 32'd0;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base0, base1, n, cnt;
    rst     = 1'b1;
    core_en = 1'b1;
    bus.core_read_request_ready = 1'b1;
    bus.req_read_data_ready     = '1;
    bus.core_read_data_valid    = 1'b0;
    bus.core_read_data          = 32'd0;
    for (int i = 0; i < NR; i++) begin beats_m[i] = 0; rdy_pulses[i] = 0; end
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_core_req_valid", bus.core_read_request_valid, 1'b0);
    chk("rst_req_ready", bus.req_read_request_ready, 32'd0);
    chk("rst_data_valid", bus.req_read_data_valid, 32'd0);
    chk("rst_core_dready", bus.core_read_data_ready, 1'b0);
    chk("rst_grant_id", grant_id, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_core_addr", bus.core_read_addr, 32'd0);
    chk("rst_core_len", bus.core_read_len, 32'd0);
    cyc();
    rst = 1'b0;

    // Single master, 4-beat burst.
    mq[0].push_back('{32'h100, 32'd3});
    @(negedge clk);
    chk("t1_arb_cycle_busy", busy, 1'b0);
    @(negedge clk);
    chk("t1_req_valid", bus.core_read_request_valid, 1'b1);
    chk("t1_req_addr", bus.core_read_addr, 32'h100);
    chk("t1_busy", busy, 1'b1);
    wait_drain(60, "t1_drain");
    chk("t1_beats_m0", beats_m[0], 32'd4);
    chk("t1_beats_m1", beats_m[1], 32'd0);

    // Both masters continuously requesting single beats.
    cyc();
    grant_log.delete();
    for (int j = 0; j < 3; j++) begin
      mq[0].push_back('{32'h1000 + 32'(j * 16), 32'd0});
      mq[1].push_back('{32'h1100 + 32'(j * 16), 32'd0});
    end
    wait_drain(100, "t2_drain");
    chk("t2_grant_count", grant_log.size(), 32'd6);
    for (int j = 0; j < 6 && j < grant_log.size(); j++)
      chk("t2_grant_seq", grant_log[j], (j % 2 == 0) ? 32'd1 : 32'd0);

    // Request held off by the core for several cycles.
    cyc();
    bus.core_read_request_ready = 1'b0;
    base1 = rdy_pulses[1];
    mq[1].push_back('{32'h2000, 32'd0});
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t3_req_valid_held", bus.core_read_request_valid, 1'b1);
      chk("t3_addr_stable", bus.core_read_addr, 32'h2000);
    end
    cyc();
    bus.core_read_request_ready = 1'b1;
    wait_drain(40, "t3_drain");
    chk("t3_ready_pulses", rdy_pulses[1] - base1, 32'd1);

    // Granted master throttles data_ready during an 8-beat burst.
    base0 = beats_m[0];
    base1 = beats_m[1];
    mq[1].push_back('{32'h3000, 32'd7});
    n = 0;
    while (beats_m[1] - base1 < 8 && n < 100) begin
      cyc();
      bus.req_read_data_ready[0] = 1'b1;
      bus.req_read_data_ready[1] = (n == 4 || n == 5 || n == 6) ? 1'b0 : 1'(($urandom_range(0, 2)) != 0);
      n++;
    end
    cyc();
    bus.req_read_data_ready = '1;
    wait_drain(40, "t4_drain");
    chk("t4_beats_m1", beats_m[1] - base1, 32'd8);
    chk("t4_beats_m0", beats_m[0] - base0, 32'd0);

    // Reset in the middle of a burst.
    base0 = beats_m[0];
    mq[0].push_back('{32'h4000, 32'd7});
    n = 0;
    while (beats_m[0] - base0 < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_beats", beats_m[0] - base0, 32'd2);
    cyc();
    rst = 1'b1;
    mq[0].delete();
    @(negedge clk);
    @(negedge clk);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_req_valid", bus.core_read_request_valid, 1'b0);
    chk("t5_rst_data_valid", bus.req_read_data_valid, 32'd0);
    chk("t5_rst_core_dready", bus.core_read_data_ready, 1'b0);
    chk("t5_rst_grant_id", grant_id, 32'd0);
    chk("t5_rst_req_data", bus.req_read_data, 32'd0);
    cyc();
    rst = 1'b0;
    grant_log.delete();
    mq[0].push_back('{32'h4100, 32'd0});
    mq[1].push_back('{32'h4200, 32'd0});
    wait_drain(60, "t5_drain");
    chk("t5_grant_count", grant_log.size(), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("t5_first_grant_m0", grant_log[0], 32'd0);
      chk("t5_second_grant_m1", grant_log[1], 32'd1);
    end

    // Core never returns data after the request handshake.
    cyc();
    core_en = 1'b0;
    grant_log.delete();
`ifdef RD_ARB_TIMEOUT_EN
    mq[0].push_back('{32'h5000, 32'd1});
    mq[1].push_back('{32'h6000, 32'd0});
    n = 0;
    @(negedge clk);
    while (!(bus.core_read_request_valid && bus.core_read_request_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_handshake_seen", 32'(n < 20), 32'd1);
    @(posedge clk);
    cnt = 0;
    while (!timeout_err && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("t6_timeout_cycles", cnt, 32'(TO));
    chk("t6_idle_after_timeout", busy, 1'b0);
    core_pend.delete();
    exp_b.delete();
    core_en = 1'b1;
    wait_drain(60, "t6_drain");
    chk("t6_timeout_sticky", timeout_err, 1'b1);
    chk("t6_grant_count", grant_log.size(), 32'd2);
    if (grant_log.size() >= 2) chk("t6_next_grant_m1", grant_log[1], 32'd1);
`else
    mq[0].push_back('{32'h5000, 32'd0});
    repeat (30) cyc();
    @(negedge clk);
    chk("t6_hung_busy", busy, 1'b1);
    chk("t6_no_timeout", timeout_err, 1'b0);
    chk("t6_hung_grant", grant_id, 32'd0);
    cyc();
    core_en = 1'b1;
    wait_drain(40, "t6_drain");
    chk("t6_grant_count", grant_log.size(), 32'd1);
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
